// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues one instruction-memory request at a time,
// holds the returned word for decode, and drops responses made stale by a redirect.
module fetch_unit #(
    parameter logic [12:0] RESET_PC = 13'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [12:0] redirect_pc,
    output logic        imem_req,
    output logic [12:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [12:0] pc_out,
    output logic [12:0] pc_plus4
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    localparam logic [12:0] RESET_PC_ALIGNED = {RESET_PC[12:2], 2'b00};

    state_t      state_q;
    logic [12:0] pc_q;
    logic [12:0] pc_out_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;

    logic [12:0] redir_pc_d;
    logic [12:0] pc_inc_d;

    assign redir_pc_d = {redirect_pc[12:2], 2'b00};
    assign pc_inc_d   = pc_q + 13'd4;

    // Fetch control FSM; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC_ALIGNED;
            pc_out_q <= RESET_PC_ALIGNED;
            instr_q  <= 32'h0000_0000;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                        if (imem_gnt) begin
                            state_q <= DROP;
                            req_q   <= 1'b0;
                        end
                    end else if (imem_gnt) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                        if (imem_rvalid) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (imem_rvalid) begin
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_inc_d;
                        valid_q  <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    // A redirect kills the held word even if decode is taking it this cycle.
                    if (redirect_valid) begin
                        pc_q    <= redir_pc_d;
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end else if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                DROP: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                    end
                    if (imem_rvalid) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 13'd4;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC SHALL be: RESET_PC, default 13'h0000, byte address loaded into the PC on reset.
REQ-002 Port clk SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port redirect_valid SHALL be: redirect_valid  input  1  branch/jump taken, load redirect_pc.
REQ-005 Port redirect_pc SHALL be: redirect_pc  input  13  new fetch byte address (selected next-PC).
REQ-006 Port imem_req SHALL be: imem_req  output  1  instruction-memory request.
REQ-007 Port imem_addr SHALL be: imem_addr  output  13  request byte address.
REQ-008 Port imem_gnt SHALL be: imem_gnt  input  1  request accepted this cycle.
REQ-009 Port imem_rvalid SHALL be: imem_rvalid  input  1  response data valid.
REQ-010 Port imem_rdata SHALL be: imem_rdata  input  32  instruction word.
REQ-011 Port instr_valid SHALL be: instr_valid  output  1  instr/pc_out hold a valid fetched instruction.
REQ-012 Port instr_ready SHALL be: instr_ready  input  1  decode accepts instruction.
REQ-013 Port instr SHALL be: instr  output  32  fetched instruction.
REQ-014 Port pc_out SHALL be: pc_out  output  13  address of instr.
REQ-015 Port pc_plus4 SHALL be: pc_plus4  output  13  pc_out+4, link value for jal.

Function
REQ-016 Internal pc SHALL hold the next fetch address; imem_addr SHALL equal pc whenever imem_req=1.
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-018 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-019 REQ: imem_req=1; gnt without redirect -> WAIT; redirect without gnt -> pc<=redirect_pc, stay REQ; redirect with gnt -> pc<=redirect_pc, DROP.
REQ-020 WAIT: imem_req=0; rvalid without redirect -> instr<=imem_rdata, pc_out<=pc, pc<=pc+4, instr_valid<=1, HOLD.
REQ-021 WAIT with redirect and no rvalid -> pc<=redirect_pc, DROP; redirect with rvalid -> data discarded, pc<=redirect_pc, REQ.
REQ-022 DROP: imem_req=0; rvalid -> response discarded, REQ; redirect in DROP SHALL update pc and remain in/leave DROP per rvalid.
REQ-023 HOLD: instr, pc_out, instr_valid SHALL remain stable while instr_ready=0.
REQ-024 HOLD with instr_ready=1 -> instr_valid<=0, REQ; handshake completes only when instr_valid and instr_ready both 1.
REQ-025 HOLD with redirect_valid=1 SHALL clear instr_valid, load pc<=redirect_pc, go REQ, regardless of instr_ready.
REQ-026 redirect_valid SHALL take priority over every other event in every state.
REQ-027 pc+4 and pc_plus4 SHALL wrap modulo 2^13 (13'h1FFC+4 = 13'h0000).
REQ-028 redirect_pc[1:0] SHALL be ignored and pc[1:0] SHALL always be 2'b00.
REQ-029 pc_plus4 SHALL be combinational from pc_out.
REQ-030 A fetched instruction SHALL reach instr_valid exactly one edge after the imem_rvalid cycle.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=32'h0, pc_out=RESET_PC.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request; an imem_rvalid arriving after reset release while in IDLE/REQ SHALL be ignored.

Verification
REQ-033 Reset release, gnt=1 each REQ, rvalid 1 cycle after gnt, instr_ready=1 -> imem_addr sequence 0x000,0x004,0x008; instr matches rdata; pc_plus4 = pc_out+4.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr/pc_out unchanged, imem_req=0 throughout; released on first ready.
REQ-035 redirect_valid with redirect_pc=13'h0100 during WAIT -> late response dropped, next imem_addr=0x100, no instr_valid for old address.
REQ-036 redirect coincident with gnt in REQ -> DROP, stale rvalid discarded, next request at redirect_pc.
REQ-037 redirect_pc=13'h1FFC, fetch completes -> pc_out=0x1FFC, pc_plus4=0x000, next imem_addr=0x000.
REQ-038 rst asserted asynchronously in WAIT -> outputs reset same cycle; first post-reset imem_addr=RESET_PC.
